// File: rtl/jk_ff_bank.sv
// -----------------------------------------------------------------------------
// jk_ff_bank
//   A WIDTH-channel bank of edge-triggered flip-flops. A run-time mode picks
//   JK, T, D or SR behaviour for every channel. The bank also provides a clock
//   enable, a synchronous parallel load, per-bit change pulses, a saturating
//   flip counter and a sticky SR-conflict flag.
//
// Parameters
//   WIDTH      number of flip-flop channels (1..64)
//   RESET_VAL  value of Q while areset is high
//   CNT_W      width of the flip counter (2..32)
//
// Ports
//   clk          rising-edge clock
//   areset       asynchronous active-high reset
//   en           enables mode-driven updates
//   mode         00=JK, 01=T, 10=D, 11=SR
//   j, k         per-channel inputs; their meaning depends on mode
//   load         synchronous parallel load, overrides en and mode
//   load_val     value written by load
//   clr_stats    synchronous clear of flip_cnt and sr_conflict
//   Q            flip-flop state
//   changed      one-cycle pulse on every bit that changed at the last edge
//   flip_cnt     saturating count of bit flips
//   sr_conflict  sticky flag: S=R=1 was seen in SR mode while enabled
// -----------------------------------------------------------------------------
module jk_ff_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_stats,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] changed,
    output logic [CNT_W-1:0] flip_cnt,
    output logic             sr_conflict
);

    localparam logic [1:0] MODE_JK = 2'b00;
    localparam logic [1:0] MODE_T  = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_SR = 2'b11;

    localparam int PC_W = $clog2(WIDTH + 1);
    // The sum is made wide enough for either operand plus a carry, so a full
    // popcount added to a narrow counter cannot wrap before saturation.
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W - CNT_W){1'b0}}, {CNT_W{1'b1}}};

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] changed_q, changed_d;
    logic [CNT_W-1:0] flip_cnt_q, flip_cnt_d;
    logic             sr_conflict_q, sr_conflict_d;

    logic [WIDTH-1:0] mode_next;
    logic [PC_W-1:0]  pop_cnt;
    logic [SUM_W-1:0] cnt_sum;
    logic             conflict_now;

    // Next state of one channel under the mode-driven rules.
    function automatic logic bit_next(input logic [1:0] md, input logic jb,
                                      input logic kb, input logic qb);
        logic nb;
        nb = qb;
        case (md)
            MODE_JK: begin
                case ({jb, kb})
                    2'b01:   nb = 1'b0;
                    2'b10:   nb = 1'b1;
                    2'b11:   nb = ~qb;
                    default: nb = qb;
                endcase
            end
            MODE_T:  nb = jb ? ~qb : qb;
            MODE_D:  nb = jb;
            // S=R=1 holds the bit; the conflict is flagged separately.
            default: begin
                case ({jb, kb})
                    2'b10:   nb = 1'b1;
                    2'b01:   nb = 1'b0;
                    default: nb = qb;
                endcase
            end
        endcase
        return nb;
    endfunction

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign mode_next[gi] = bit_next(mode, j[gi], k[gi], q_q[gi]);
        end
    endgenerate

    assign conflict_now = (mode == MODE_SR) && (|(j & k));

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_val;
        end else if (en) begin
            q_d = mode_next;
        end

        changed_d = q_d ^ q_q;

        pop_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_cnt = pop_cnt + PC_W'(changed_d[i]);
        end

        // clr_stats clears first, then this edge's flips are accumulated.
        cnt_sum = (clr_stats ? '0 : SUM_W'(flip_cnt_q)) + SUM_W'(pop_cnt);
        if (cnt_sum > CNT_MAX) begin
            flip_cnt_d = CNT_MAX[CNT_W-1:0];
        end else begin
            flip_cnt_d = cnt_sum[CNT_W-1:0];
        end

        // A new conflict wins over a simultaneous clear.
        sr_conflict_d = (!load && en && conflict_now) || (sr_conflict_q && !clr_stats);
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            q_q           <= RESET_VAL;
            changed_q     <= '0;
            flip_cnt_q    <= '0;
            sr_conflict_q <= 1'b0;
        end else begin
            q_q           <= q_d;
            changed_q     <= changed_d;
            flip_cnt_q    <= flip_cnt_d;
            sr_conflict_q <= sr_conflict_d;
        end
    end

    assign Q           = q_q;
    assign changed     = changed_q;
    assign flip_cnt    = flip_cnt_q;
    assign sr_conflict = sr_conflict_q;

endmodule

// File: tb/tb_jk_ff_bank.sv
// -----------------------------------------------------------------------------
// tb_jk_ff_bank
//   Directed and random stimulus for jk_ff_bank. Two instances share every
//   input: dut_a (CNT_W=16) and dut_b (CNT_W=4, for counter saturation).
//   A behavioural model pushes expected results into a queue when stimulus is
//   driven. The entries are popped and compared after the clock edge.
// -----------------------------------------------------------------------------
module tb_jk_ff_bank;

    logic       clk = 1'b0;
    logic       areset = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] j = '0, k = '0, load_val = '0;
    logic       load = 1'b0;
    logic       clr_stats = 1'b0;

    logic [7:0]  q_a, chg_a, q_b, chg_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;
    logic        sr_a, sr_b;

    always #5 clk = ~clk;

    jk_ff_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .CNT_W(16)) dut_a (
        .clk(clk), .areset(areset), .en(en), .mode(mode), .j(j), .k(k),
        .load(load), .load_val(load_val), .clr_stats(clr_stats),
        .Q(q_a), .changed(chg_a), .flip_cnt(cnt_a), .sr_conflict(sr_a)
    );

    jk_ff_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .CNT_W(4)) dut_b (
        .clk(clk), .areset(areset), .en(en), .mode(mode), .j(j), .k(k),
        .load(load), .load_val(load_val), .clr_stats(clr_stats),
        .Q(q_b), .changed(chg_b), .flip_cnt(cnt_b), .sr_conflict(sr_b)
    );

    typedef struct {
        logic [7:0]  q;
        logic [7:0]  chg;
        logic [15:0] cnt_a;
        logic [3:0]  cnt_b;
        logic        sr;
    } exp_t;

    exp_t sb[$];

    int vectors     = 0;
    int miscompares = 0;

    // Model state
    logic [7:0] m_q;
    int         m_cnt_a, m_cnt_b;
    logic       m_sr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q = 8'hA5;
        m_cnt_a = 0;
        m_cnt_b = 0;
        m_sr = 1'b0;
    endtask

    // Drive one edge worth of stimulus, queue the model's prediction, then
    // pop and compare after the edge.
    task automatic drive(input string tag, input logic l, input logic e,
                         input logic [1:0] md, input logic [7:0] jj,
                         input logic [7:0] kk, input logic [7:0] lv,
                         input logic cs);
        exp_t       ex;
        exp_t       got;
        logic [7:0] nq;
        int         pc;

        load = l; en = e; mode = md; j = jj; k = kk; load_val = lv; clr_stats = cs;

        nq = m_q;
        if (l) begin
            nq = lv;
        end else if (e) begin
            for (int i = 0; i < 8; i++) begin
                case (md)
                    2'd0: begin
                        if (jj[i] && kk[i])       nq[i] = ~m_q[i];
                        else if (jj[i])           nq[i] = 1'b1;
                        else if (kk[i])           nq[i] = 1'b0;
                    end
                    2'd1: if (jj[i]) nq[i] = ~m_q[i];
                    2'd2: nq[i] = jj[i];
                    default: begin
                        if (jj[i] && !kk[i])      nq[i] = 1'b1;
                        else if (!jj[i] && kk[i]) nq[i] = 1'b0;
                    end
                endcase
            end
        end
        ex.chg = nq ^ m_q;
        pc = $countones(ex.chg);
        m_cnt_a = cs ? pc : ((m_cnt_a + pc > 65535) ? 65535 : m_cnt_a + pc);
        m_cnt_b = cs ? pc : ((m_cnt_b + pc > 15) ? 15 : m_cnt_b + pc);
        m_sr = (!l && e && md == 2'd3 && (|(jj & kk))) || (m_sr && !cs);
        m_q = nq;
        ex.q = nq;
        ex.cnt_a = 16'(m_cnt_a);
        ex.cnt_b = 4'(m_cnt_b);
        ex.sr = m_sr;
        sb.push_back(ex);

        @(posedge clk);
        #1;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            got = sb.pop_front();
            check({tag, "_q"},     q_a,   got.q);
            check({tag, "_q_b"},   q_b,   got.q);
            check({tag, "_chg"},   chg_a, got.chg);
            check({tag, "_chg_b"}, chg_b, got.chg);
            check({tag, "_cnt"},   cnt_a, got.cnt_a);
            check({tag, "_cnt_b"}, cnt_b, got.cnt_b);
            check({tag, "_sr"},    sr_a,  got.sr);
            check({tag, "_sr_b"},  sr_b,  got.sr);
        end
        $display("%s: load=%b en=%b mode=%0d j=%h k=%h lv=%h clr=%b -> Q=%h chg=%h cnt=%0d/%0d sr=%b",
                 tag, l, e, md, jj, kk, lv, cs, q_a, chg_a, cnt_a, cnt_b, sr_a);
    endtask

    initial begin
        // ---- Asynchronous reset, applied mid-cycle ----
        #12;
        areset = 1'b1;
        model_reset();
        #1;
        check("rst_q",   q_a,   8'hA5);
        check("rst_chg", chg_a, 8'h00);
        check("rst_cnt", cnt_a, 16'd0);
        check("rst_sr",  sr_a,  1'b0);
        check("rst_q_b", q_b,   8'hA5);
        $display("reset: Q=%h chg=%h cnt=%0d sr=%b", q_a, chg_a, cnt_a, sr_a);

        // A load strobe under reset must be discarded.
        load = 1'b1; load_val = 8'h00;
        @(posedge clk);
        #1;
        check("rst_hold_q", q_a, 8'hA5);
        $display("reset hold: Q=%h", q_a);
        @(negedge clk);
        areset = 1'b0;
        load = 1'b0;

        // ---- Bring Q to 00 and clear stats ----
        drive("init_load", 1, 0, 2'd0, 8'h00, 8'h00, 8'h00, 0);
        check("init_load_chg", chg_a, 8'hA5);
        drive("init_clr", 0, 0, 2'd0, 8'h00, 8'h00, 8'h00, 1);
        check("init_clr_cnt", cnt_a, 16'd0);

        // ---- JK truth table ----
        drive("jk_set", 0, 1, 2'd0, 8'hFF, 8'h00, 8'h00, 0);
        check("jk_set_q", q_a, 8'hFF); check("jk_set_chg", chg_a, 8'hFF); check("jk_set_cnt", cnt_a, 16'd8);
        drive("jk_clr", 0, 1, 2'd0, 8'h00, 8'h0F, 8'h00, 0);
        check("jk_clr_q", q_a, 8'hF0); check("jk_clr_chg", chg_a, 8'h0F); check("jk_clr_cnt", cnt_a, 16'd12);
        drive("jk_tog", 0, 1, 2'd0, 8'hFF, 8'hFF, 8'h00, 0);
        check("jk_tog_q", q_a, 8'h0F); check("jk_tog_chg", chg_a, 8'hFF); check("jk_tog_cnt", cnt_a, 16'd20);
        drive("jk_hold", 0, 1, 2'd0, 8'h00, 8'h00, 8'h00, 0);
        check("jk_hold_q", q_a, 8'h0F); check("jk_hold_chg", chg_a, 8'h00); check("jk_hold_cnt", cnt_a, 16'd20);

        // ---- Mode sweep ----
        drive("sw_load", 1, 0, 2'd0, 8'h00, 8'h00, 8'h00, 0);
        drive("t_1", 0, 1, 2'd1, 8'h81, 8'h5A, 8'h00, 0);
        check("t_1_q", q_a, 8'h81);
        drive("t_2", 0, 1, 2'd1, 8'h81, 8'hA5, 8'h00, 0);
        check("t_2_q", q_a, 8'h00);
        drive("d_1", 0, 1, 2'd2, 8'h3C, 8'hFF, 8'h00, 0);
        check("d_1_q", q_a, 8'h3C);
        drive("en_off", 0, 0, 2'd0, 8'hFF, 8'hFF, 8'h00, 0);
        check("en_off_q", q_a, 8'h3C); check("en_off_chg", chg_a, 8'h00);

        // ---- SR conflict ----
        drive("sr_load", 1, 0, 2'd0, 8'h00, 8'h00, 8'h00, 0);
        drive("sr_conf", 0, 1, 2'd3, 8'h01, 8'h01, 8'h00, 0);
        check("sr_conf_q", q_a, 8'h00); check("sr_conf_flag", sr_a, 1'b1);
        drive("sr_clr", 0, 0, 2'd0, 8'h00, 8'h00, 8'h00, 1);
        check("sr_clr_flag", sr_a, 1'b0); check("sr_clr_cnt", cnt_a, 16'd0);
        drive("sr_clr_conf", 0, 1, 2'd3, 8'h01, 8'h01, 8'h00, 1);
        check("sr_clr_conf_flag", sr_a, 1'b1);

        // ---- Load priority and saturation (dut_b, CNT_W=4) ----
        drive("sat_clr", 0, 0, 2'd0, 8'h00, 8'h00, 8'h00, 1);
        drive("sat_load", 1, 1, 2'd1, 8'hFF, 8'h00, 8'hF0, 0);
        check("sat_load_q", q_b, 8'hF0); check("sat_load_cnt", cnt_b, 4'd4);
        drive("sat_t1", 0, 1, 2'd1, 8'hFF, 8'h00, 8'h00, 0);
        check("sat_t1_cnt", cnt_b, 4'd12);
        drive("sat_t2", 0, 1, 2'd1, 8'hFF, 8'h00, 8'h00, 0);
        check("sat_t2_cnt", cnt_b, 4'd15);
        drive("sat_t3", 0, 1, 2'd1, 8'hFF, 8'h00, 8'h00, 0);
        check("sat_t3_cnt", cnt_b, 4'd15); check("sat_t3_q", q_b, 8'h0F);

        // ---- Randomised compare against the model ----
        for (int n = 0; n < 400; n++) begin
            drive($sformatf("rnd%0d", n),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)),
                  8'($urandom), 8'($urandom), 8'($urandom),
                  ($urandom_range(0, 15) == 0));
        end

        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
